dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between NUM_CORES processor cores. Each core's control FSM issues load and store requests to the memory.
- Fair round-robin arbitration. One memory access in flight at a time. Each request gets exactly one acknowledge pulse.
- Sits between the core control/datapath (stac/loadac memory phases) and the data RAM in the multi-core top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- core_req  in  NUM_CORES  per-core request; held high until that core's ack
- core_we  in  NUM_CORES  per-core write enable (1=store, 0=load); valid while req
- core_addr  in  NUM_CORES*ADDR_W  flattened addresses; core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened write data, same packing
- core_ack  out  NUM_CORES  one-cycle acknowledge pulse to the winning core
- core_rdata  out  DATA_W  shared read-data bus; valid when an ack bit is set for a load
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid one cycle after the mem_en cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async):
  - state=IDLE; rr_ptr=0, so core 0 has highest priority.
  - All outputs 0. mem_en drops immediately, with no clock edge required.
  - An access in flight is abandoned and no ack is issued. Cores re-request after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any core_req is set, latch winner index `win` and that core's we/addr/wdata into registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1. mem_we/mem_addr/mem_wdata come from the latched registers.
  - Go to RESP unconditionally.
- RESP:
  - core_ack[win]=1.
  - core_rdata=mem_rdata for loads; core_rdata=0 for stores.
  - rr_ptr updates to (win+1) mod NUM_CORES.
  - Back-to-back: if any core_req other than win is set, pick a new winner with the updated pointer, latch it, and go to ISSUE. Otherwise go to IDLE.
  - core_req[win] is masked in RESP, because the winning core still holds req during its ack cycle.
- Latency and throughput:
  - Request seen in IDLE at cycle N: mem_en in N+1, ack in N+2.
  - Back-to-back throughput: one access per 2 cycles.
- Round-robin pick:
  - Search the candidates starting at rr_ptr, ascending with wrap.
  - The first set bit wins.
  - rr_ptr changes only in RESP.
- Outputs outside ISSUE and RESP:
  - mem_en, mem_we = 0.
  - core_ack = 0; core_rdata = 0.
- Request changes: a request that drops before ack is ignored once latched. The latched copy is used, so the access still completes and acks.
- Masking: core_req bits at or above NUM_CORES do not exist; no masking is needed beyond the parameter width.
- Edge cases:
  - All cores requesting continuously: grants cycle 0,1,2,3,0… with no starvation.
  - Single requester re-requesting immediately after ack: served again after one IDLE cycle.
  - Simultaneous reset and request: reset wins.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - pointer width function clog2(NUM_CORES)
- Sub-module rr_pick:
  - combinational round-robin priority picker
  - inputs: req vector, rr_ptr, mask
  - outputs: valid, win index
  - used in both IDLE and RESP

Test Plan:
- Single load: memory preloaded mem[0x0010]=0xBEEF; core 1 req, we=0, addr=0x0010 -> mem_en at +1 cycle, core_ack=4'b0010 and core_rdata=0xBEEF at +2, then IDLE.
- Single store then load: core 2 stores 0x1234 at 0x0005, then loads 0x0005 -> one mem_en with mem_we=1 and mem_addr=0x0005, ack pulse; the load then returns 0x1234.
- All four cores request continuously from reset -> acks in order 0,1,2,3,0,1 at a 2-cycle spacing; mem_en never idle between them.
- Cores 0 and 3 request while rr_ptr=1 -> core 3 granted first, then core 0; exactly one ack per core.
- Reset mid-access: assert rst during ISSUE -> mem_en falls immediately, no ack, busy=0; after release, core 0 has priority.
- Requester drops core_req during ISSUE -> access still completes and acks; no second access for that core.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Width of a core index / round-robin pointer (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or after rr_ptr.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  input  logic [N-1:0]  mask,
  output logic          valid,
  output logic [PW-1:0] win
);

  localparam int unsigned SW = PW + 1;

  logic [N-1:0]   cand_c;
  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [SW-1:0]  sum_c;

  // Rotate candidates so rr_ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    cand_c = req & ~mask;
    dbl_c  = {cand_c, cand_c} >> rr_ptr;
    rot_c  = dbl_c[N-1:0];
    valid  = 1'b0;
    win    = '0;
    sum_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && rot_c[i]) begin
        valid = 1'b1;
        sum_c = SW'(rr_ptr) + SW'(i);
        if (sum_c >= SW'(N)) begin
          sum_c = sum_c - SW'(N);
        end
        win = sum_c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM among cores.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int unsigned PTR_W = ptr_width(NUM_CORES);

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;

  logic                 mem_en_q, mem_we_q, busy_q;
  logic [NUM_CORES-1:0] ack_q, ack_d;

  logic [PTR_W-1:0]     ptr_inc_c, pick_ptr_c, pick_win_c;
  logic [NUM_CORES-1:0] win_mask_c, pick_mask_c;
  logic                 pick_valid_c;
  logic                 sel_we_c;
  logic [ADDR_W-1:0]    sel_addr_c;
  logic [DATA_W-1:0]    sel_wdata_c;

  // Pointer after the current winner, and the winner's own request mask.
  always_comb begin
    ptr_inc_c  = (win_q == PTR_W'(NUM_CORES - 1)) ? '0 : win_q + PTR_W'(1);
    win_mask_c = '0;
    win_mask_c[win_q] = 1'b1;
  end

  // In RESP the search starts past the current winner, whose req is still high.
  always_comb begin
    pick_ptr_c  = rr_ptr_q;
    pick_mask_c = '0;
    if (state_q == RESP) begin
      pick_ptr_c  = ptr_inc_c;
      pick_mask_c = win_mask_c;
    end
  end

  rr_pick #(
    .N  (NUM_CORES),
    .PW (PTR_W)
  ) u_rr_pick (
    .req    (core_req),
    .rr_ptr (pick_ptr_c),
    .mask   (pick_mask_c),
    .valid  (pick_valid_c),
    .win    (pick_win_c)
  );

  // Select the picked core's request fields for latching.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (pick_win_c == PTR_W'(i)) begin
        sel_we_c    = core_we[i];
        sel_addr_c  = core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic; a grant latches the request so later req changes are ignored.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          win_d   = pick_win_c;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        rr_ptr_d = ptr_inc_c;
        if (pick_valid_c) begin
          win_d   = pick_win_c;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == RESP) begin
      ack_d[win_d] = 1'b1;
    end
  end

  // State, latched request and registered outputs; reset abandons any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_en_q <= (state_d == ISSUE);
      mem_we_q <= (state_d == ISSUE) && we_d;
      ack_q    <= ack_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // RAM read data arrives in RESP, so it is steered straight onto the shared bus.
  always_comb begin
    core_rdata = '0;
    if ((state_q == RESP) && !we_q) begin
      core_rdata = mem_rdata;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_ack  = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_we;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [NC-1:0]     core_ack;
  logic [DW-1:0]     core_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  dmem_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data valid the cycle after mem_en.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic [1:0]  core;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  exp_ack;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  got_ack   [8];
  logic [15:0] got_rdata [8];
  int          got_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input logic [1:0] c, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata);
    core_we[c] = we;
    core_addr[int'(c)*16 +: 16]  = addr;
    core_wdata[int'(c)*16 +: 16] = wdata;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  // Records acks for ncyc cycles; each acked core drops its request.
  task automatic collect_acks(input int ncyc);
    got_n = 0;
    for (int k = 0; k < 8; k++) begin
      got_ack[k]   = '0;
      got_rdata[k] = '0;
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (core_ack != '0) begin
        if (got_n < 8) begin
          got_ack[got_n]   = core_ack;
          got_rdata[got_n] = core_rdata;
        end
        got_n++;
        core_req = core_req & ~core_ack;
      end
    end
  endtask

  // One isolated transaction, checked cycle by cycle; called at a negedge while idle.
  task automatic run_txn(input int idx, input vec_t v);
    set_core(v.core, v.we, v.addr, v.wdata);
    core_req[v.core] = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'd1);
    chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.we));
    chk($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
    if (v.we) chk($sformatf("v%0d_mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
    chk($sformatf("v%0d_early_ack", idx), 32'(core_ack), 32'd0);
    chk($sformatf("v%0d_early_rdata", idx), 32'(core_rdata), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_ack", idx), 32'(core_ack), 32'(v.exp_ack));
    chk($sformatf("v%0d_rdata", idx), 32'(core_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d_resp_mem_en", idx), 32'(mem_en), 32'd0);
    core_req[v.core] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_after_ack", idx), 32'(core_ack), 32'd0);
    chk($sformatf("v%0d_after_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] order [6];
    int         a_cyc [6];
    logic [3:0] a_val [6];
    int         n_ack;

    vecs[0] = '{core: 2'd1, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_ack: 4'b0010, exp_rdata: 16'hBEEF};
    vecs[1] = '{core: 2'd2, we: 1'b1, addr: 16'h0005, wdata: 16'h1234, exp_ack: 4'b0100, exp_rdata: 16'h0000};
    vecs[2] = '{core: 2'd2, we: 1'b0, addr: 16'h0005, wdata: 16'h0000, exp_ack: 4'b0100, exp_rdata: 16'h1234};
    vecs[3] = '{core: 2'd0, we: 1'b1, addr: 16'h0020, wdata: 16'hA5A5, exp_ack: 4'b0001, exp_rdata: 16'h0000};
    vecs[4] = '{core: 2'd3, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, exp_ack: 4'b1000, exp_rdata: 16'hA5A5};
    vecs[5] = '{core: 2'd0, we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, exp_ack: 4'b0001, exp_rdata: 16'h5A5A};

    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0010;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'hBEEF;
    mem[8'hFF] = 16'h5A5A;
    mem_rdata  = '0;

    rst        = 1'b1;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;

    // All four request while reset is held: reset wins, outputs stay quiet.
    set_core(2'd0, 1'b0, 16'h0010, 16'h0);
    set_core(2'd1, 1'b0, 16'h0005, 16'h0);
    set_core(2'd2, 1'b0, 16'h0020, 16'h0);
    set_core(2'd3, 1'b0, 16'h00FF, 16'h0);
    core_req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ack", 32'(core_ack), 32'd0);
    chk("reset_rdata", 32'(core_rdata), 32'd0);

    // Continuous requests: grants rotate 0,1,2,3,0,1 every two cycles.
    rst   = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 6; k++) begin
      a_cyc[k] = 0;
      a_val[k] = '0;
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("all4_mem_en_c%0d", k), 32'(mem_en), 32'(k % 2));
      if (core_ack != '0) begin
        if (n_ack < 6) begin
          a_val[n_ack] = core_ack;
          a_cyc[n_ack] = k;
        end
        n_ack++;
      end
    end
    core_req = '0;
    chk("all4_n_acks", 32'(n_ack), 32'd7);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("all4_ack%0d", i), 32'(a_val[i]), 32'(order[i]));
      chk($sformatf("all4_cyc%0d", i), 32'(a_cyc[i]), 32'(2 + 2 * i));
    end
    wait_idle();

    // Isolated loads and stores from the vector table.
    for (int i = 0; i < 6; i++) begin
      run_txn(i, vecs[i]);
    end

    // Pointer now at 1: core 3 must beat core 0.
    set_core(2'd0, 1'b0, 16'h0010, 16'h0);
    set_core(2'd3, 1'b0, 16'h0020, 16'h0);
    core_req = 4'b1001;
    collect_acks(12);
    chk("rr_n_acks", 32'(got_n), 32'd2);
    chk("rr_first_ack", 32'(got_ack[0]), 32'b1000);
    chk("rr_first_rdata", 32'(got_rdata[0]), 32'hA5A5);
    chk("rr_second_ack", 32'(got_ack[1]), 32'b0001);
    chk("rr_second_rdata", 32'(got_rdata[1]), 32'hBEEF);
    wait_idle();

    // Request withdrawn during ISSUE still completes exactly once.
    set_core(2'd1, 1'b0, 16'h0005, 16'h0);
    core_req = 4'b0010;
    @(negedge clk);
    chk("drop_mem_en", 32'(mem_en), 32'd1);
    core_req = '0;
    @(negedge clk);
    chk("drop_ack", 32'(core_ack), 32'b0010);
    chk("drop_rdata", 32'(core_rdata), 32'h1234);
    collect_acks(6);
    chk("drop_no_extra_ack", 32'(got_n), 32'd0);
    chk("drop_idle", 32'(busy), 32'd0);

    // Reset during ISSUE: mem_en falls without a clock edge and no ack follows.
    set_core(2'd2, 1'b1, 16'h0030, 16'h7777);
    core_req = 4'b0100;
    @(negedge clk);
    chk("rst_mid_mem_en_before", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(core_ack), 32'd0);
    core_req = '0;
    @(negedge clk);
    chk("rst_mid_ack_held", 32'(core_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_write", 32'(mem[8'h30]), 32'd0);

    // After reset the pointer is back at 0: core 0 beats core 3.
    set_core(2'd0, 1'b0, 16'h0010, 16'h0);
    set_core(2'd3, 1'b0, 16'h0020, 16'h0);
    core_req = 4'b1001;
    collect_acks(12);
    chk("post_rst_n_acks", 32'(got_n), 32'd2);
    chk("post_rst_first_ack", 32'(got_ack[0]), 32'b0001);
    chk("post_rst_first_rdata", 32'(got_rdata[0]), 32'hBEEF);
    chk("post_rst_second_ack", 32'(got_ack[1]), 32'b1000);
    chk("post_rst_second_rdata", 32'(got_rdata[1]), 32'hA5A5);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
